// File: rtl/slk_axi_bridge_pkg.sv
// Shared types and helpers for the sram-to-AXI3 bridge: FSM state encodings,
// constant AXI field values and the write-strobe decode.
package slk_axi_bridge_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;

  // Byte lanes touched by a single-beat access of the given size at addr[1:0].
  function automatic logic [3:0] size_to_strb(input logic [1:0] size,
                                              input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 4'b0001 << addr_lo;
      SIZE_HALF: return 4'b0011 << {addr_lo[1], 1'b0};
      default:   return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/slk_axi_bridge_rr_arbiter.sv
// Per-direction request arbiter: round-robin (RR=1) or fixed priority with
// channel 0 highest (RR=0). idx_o names the winner even when en_i is low.
module slk_axi_bridge_rr_arbiter #(
  parameter int NCH = 3,
  parameter bit RR  = 1'b1,
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req_i,
  input  logic           en_i,
  output logic [NCH-1:0] gnt_o,
  output logic [IW-1:0]  idx_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;
  int            cand;

  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < NCH; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NCH) cand = cand - NCH;
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = IW'(cand);
      end
    end
  end

  assign gnt_o = (en_i && found) ? (NCH'(1) << idx_o) : '0;

  // The pointer only advances on a real grant, so a stalled winner keeps its turn.
  always_comb begin
    ptr_d = ptr_q;
    if (RR && en_i && found) begin
      ptr_d = (idx_o == IW'(NCH - 1)) ? '0 : idx_o + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/slk_axi_bridge.sv
// Bridges NCH sram-like request channels onto one single-beat AXI3 master,
// with one read and one write in flight and read-after-write address blocking.
module slk_axi_bridge
  import slk_axi_bridge_pkg::*;
#(
  parameter int NCH = 3,
  parameter bit RR  = 1'b1,
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  // sram-like channels
  input  logic [NCH-1:0]    req_i,
  input  logic [NCH-1:0]    wr_i,
  input  logic [NCH*2-1:0]  size_i,
  input  logic [NCH*32-1:0] addr_i,
  input  logic [NCH*32-1:0] wdata_i,
  output logic [NCH-1:0]    addr_ok_o,
  output logic [NCH-1:0]    data_ok_o,
  output logic [31:0]       rdata_o,
  // AXI read address
  output logic [3:0]        arid_o,
  output logic [31:0]       araddr_o,
  output logic [7:0]        arlen_o,
  output logic [2:0]        arsize_o,
  output logic [1:0]        arburst_o,
  output logic [1:0]        arlock_o,
  output logic [3:0]        arcache_o,
  output logic [2:0]        arprot_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  // AXI read data
  input  logic [3:0]        rid_i,
  input  logic [31:0]       rdata_i,
  input  logic [1:0]        rresp_i,
  input  logic              rlast_i,
  input  logic              rvalid_i,
  output logic              rready_o,
  // AXI write address
  output logic [3:0]        awid_o,
  output logic [31:0]       awaddr_o,
  output logic [7:0]        awlen_o,
  output logic [2:0]        awsize_o,
  output logic [1:0]        awburst_o,
  output logic [1:0]        awlock_o,
  output logic [3:0]        awcache_o,
  output logic [2:0]        awprot_o,
  output logic              awvalid_o,
  input  logic              awready_i,
  // AXI write data
  output logic [3:0]        wid_o,
  output logic [31:0]       wdata_o,
  output logic [3:0]        wstrb_o,
  output logic              wlast_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  // AXI write response
  input  logic [3:0]        bid_i,
  input  logic [1:0]        bresp_i,
  input  logic              bvalid_i,
  output logic              bready_o
);

  logic [31:0] addr_a  [NCH];
  logic [31:0] wdata_a [NCH];
  logic [1:0]  size_a  [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_unpack
    assign addr_a[g]  = addr_i[g*32 +: 32];
    assign wdata_a[g] = wdata_i[g*32 +: 32];
    assign size_a[g]  = size_i[g*2 +: 2];
  end

  rd_state_t     r_state_q, r_state_d;
  logic [IW-1:0] r_owner_q, r_owner_d;
  logic [31:0]   r_addr_q, r_addr_d;
  logic [1:0]    r_size_q, r_size_d;

  wr_state_t     w_state_q, w_state_d;
  logic [IW-1:0] w_owner_q, w_owner_d;
  logic [31:0]   w_addr_q, w_addr_d;
  logic [1:0]    w_size_q, w_size_d;
  logic [31:0]   w_data_q, w_data_d;
  logic [3:0]    w_strb_q, w_strb_d;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;

  logic [NCH-1:0] rd_gnt, wr_gnt;
  logic [IW-1:0]  rd_idx, wr_idx;
  logic           rd_hazard, rd_en, wr_en;
  logic           aw_now, w_now;

  // A read to the word the in-flight write targets must wait for its response.
  assign rd_hazard = (w_state_q != W_IDLE) && (addr_a[rd_idx][31:2] == w_addr_q[31:2]);
  assign rd_en     = (r_state_q == R_IDLE) && !rd_hazard;
  assign wr_en     = (w_state_q == W_IDLE);

  slk_axi_bridge_rr_arbiter #(.NCH(NCH), .RR(RR)) u_rd_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (req_i & ~wr_i),
    .en_i  (rd_en),
    .gnt_o (rd_gnt),
    .idx_o (rd_idx)
  );

  slk_axi_bridge_rr_arbiter #(.NCH(NCH), .RR(RR)) u_wr_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (req_i & wr_i),
    .en_i  (wr_en),
    .gnt_o (wr_gnt),
    .idx_o (wr_idx)
  );

  assign addr_ok_o = rd_gnt | wr_gnt;

  always_comb begin
    r_state_d = r_state_q;
    r_owner_d = r_owner_q;
    r_addr_d  = r_addr_q;
    r_size_d  = r_size_q;
    case (r_state_q)
      R_IDLE: if (|rd_gnt) begin
        r_state_d = R_ADDR;
        r_owner_d = rd_idx;
        r_addr_d  = addr_a[rd_idx];
        r_size_d  = size_a[rd_idx];
      end
      R_ADDR:  if (arready_i) r_state_d = R_DATA;
      R_DATA:  if (rvalid_i && rlast_i) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // AW and W complete independently; the done flags remember whichever went first.
  assign aw_now = aw_done_q || awready_i;
  assign w_now  = w_done_q || wready_i;

  always_comb begin
    w_state_d = w_state_q;
    w_owner_d = w_owner_q;
    w_addr_d  = w_addr_q;
    w_size_d  = w_size_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (w_state_q)
      W_IDLE: if (|wr_gnt) begin
        w_state_d = W_ADDR;
        w_owner_d = wr_idx;
        w_addr_d  = addr_a[wr_idx];
        w_size_d  = size_a[wr_idx];
        w_data_d  = wdata_a[wr_idx];
        w_strb_d  = size_to_strb(size_a[wr_idx], addr_a[wr_idx][1:0]);
      end
      W_ADDR: begin
        if (aw_now && w_now) begin
          w_state_d = W_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_now;
          w_done_d  = w_now;
        end
      end
      W_RESP:  if (bvalid_i) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // NOTE: the address/data latches are reset too, not just the state, because
  // they drive AXI outputs directly and must read zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_owner_q <= '0;
      r_addr_q  <= '0;
      r_size_q  <= '0;
      w_state_q <= W_IDLE;
      w_owner_q <= '0;
      w_addr_q  <= '0;
      w_size_q  <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_owner_q <= r_owner_d;
      r_addr_q  <= r_addr_d;
      r_size_q  <= r_size_d;
      w_state_q <= w_state_d;
      w_owner_q <= w_owner_d;
      w_addr_q  <= w_addr_d;
      w_size_q  <= w_size_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    data_ok_o = '0;
    if (r_state_q == R_DATA && rvalid_i && rlast_i) data_ok_o[r_owner_q] = 1'b1;
    if (w_state_q == W_RESP && bvalid_i)            data_ok_o[w_owner_q] = 1'b1;
  end

  assign rdata_o = rdata_i;

  assign arid_o    = 4'(r_owner_q);
  assign araddr_o  = r_addr_q;
  assign arlen_o   = 8'd0;
  assign arsize_o  = {1'b0, r_size_q};
  assign arburst_o = AXI_BURST_INCR;
  assign arlock_o  = 2'b00;
  assign arcache_o = 4'b0000;
  assign arprot_o  = 3'b000;
  assign arvalid_o = (r_state_q == R_ADDR);
  assign rready_o  = (r_state_q == R_DATA);

  assign awid_o    = 4'(w_owner_q);
  assign awaddr_o  = w_addr_q;
  assign awlen_o   = 8'd0;
  assign awsize_o  = {1'b0, w_size_q};
  assign awburst_o = AXI_BURST_INCR;
  assign awlock_o  = 2'b00;
  assign awcache_o = 4'b0000;
  assign awprot_o  = 3'b000;
  assign awvalid_o = (w_state_q == W_ADDR) && !aw_done_q;

  assign wid_o    = awid_o;
  assign wdata_o  = w_data_q;
  assign wstrb_o  = w_strb_q;
  assign wlast_o  = 1'b1;
  assign wvalid_o = (w_state_q == W_ADDR) && !w_done_q;
  assign bready_o = (w_state_q == W_RESP);

  // Only one transaction per direction is outstanding, so IDs and responses carry no information.
  logic unused_axi;
  assign unused_axi = ^{rid_i, rresp_i, bid_i, bresp_i};

endmodule

// File: tb/tb_slk_axi_bridge.sv
// Directed bench for slk_axi_bridge: a small AXI slave model with ready/latency
// knobs, a negedge monitor, and one task per scenario.
module tb_slk_axi_bridge;

  localparam int NCH = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NCH-1:0]    req = '0, wr = '0;
  logic [NCH*2-1:0]  size = '0;
  logic [NCH*32-1:0] addr = '0, wdata = '0;
  logic [NCH-1:0]    addr_ok, data_ok;
  logic [31:0]       rdata;

  logic [3:0]  arid, awid, wid, arcache, awcache, wstrb;
  logic [31:0] araddr, awaddr, wdata_ax;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock;
  logic        arvalid, rready, awvalid, wlast, wvalid, bready;
  logic        arready_i, rvalid_i, awready_i, wready_i, bvalid_i;
  logic [31:0] rdata_i;

  // slave knobs, driven from the test tasks
  logic        arready_k = 1'b1, awready_k = 1'b1, wready_k = 1'b1;
  int          r_delay = 0, b_delay = 0;
  logic [31:0] rdata_k = '0;

  slk_axi_bridge #(.NCH(NCH), .RR(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_i(req), .wr_i(wr), .size_i(size), .addr_i(addr), .wdata_i(wdata),
    .addr_ok_o(addr_ok), .data_ok_o(data_ok), .rdata_o(rdata),
    .arid_o(arid), .araddr_o(araddr), .arlen_o(arlen), .arsize_o(arsize),
    .arburst_o(arburst), .arlock_o(arlock), .arcache_o(arcache), .arprot_o(arprot),
    .arvalid_o(arvalid), .arready_i(arready_i),
    .rid_i(4'd0), .rdata_i(rdata_i), .rresp_i(2'b00), .rlast_i(1'b1),
    .rvalid_i(rvalid_i), .rready_o(rready),
    .awid_o(awid), .awaddr_o(awaddr), .awlen_o(awlen), .awsize_o(awsize),
    .awburst_o(awburst), .awlock_o(awlock), .awcache_o(awcache), .awprot_o(awprot),
    .awvalid_o(awvalid), .awready_i(awready_i),
    .wid_o(wid), .wdata_o(wdata_ax), .wstrb_o(wstrb), .wlast_o(wlast),
    .wvalid_o(wvalid), .wready_i(wready_i),
    .bid_i(4'd0), .bresp_i(2'b00), .bvalid_i(bvalid_i), .bready_o(bready)
  );

  // Fixed-priority instance: all three channels hold reads, slave always ready.
  logic [NCH-1:0]    fp_req = '1;
  logic [NCH-1:0]    fp_addr_ok, fp_data_ok;
  logic [31:0]       fp_rdata, fp_araddr, fp_awaddr, fp_wdata;
  logic [3:0]        fp_arid, fp_awid, fp_wid, fp_arcache, fp_awcache, fp_wstrb;
  logic [7:0]        fp_arlen, fp_awlen;
  logic [2:0]        fp_arsize, fp_awsize, fp_arprot, fp_awprot;
  logic [1:0]        fp_arburst, fp_awburst, fp_arlock, fp_awlock;
  logic              fp_arvalid, fp_rready, fp_awvalid, fp_wlast, fp_wvalid, fp_bready;

  slk_axi_bridge #(.NCH(NCH), .RR(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .req_i(fp_req), .wr_i(3'b000), .size_i(6'b101010),
    .addr_i({32'h0000_0308, 32'h0000_0304, 32'h0000_0300}), .wdata_i('0),
    .addr_ok_o(fp_addr_ok), .data_ok_o(fp_data_ok), .rdata_o(fp_rdata),
    .arid_o(fp_arid), .araddr_o(fp_araddr), .arlen_o(fp_arlen), .arsize_o(fp_arsize),
    .arburst_o(fp_arburst), .arlock_o(fp_arlock), .arcache_o(fp_arcache), .arprot_o(fp_arprot),
    .arvalid_o(fp_arvalid), .arready_i(1'b1),
    .rid_i(4'd0), .rdata_i(32'd0), .rresp_i(2'b00), .rlast_i(1'b1),
    .rvalid_i(1'b1), .rready_o(fp_rready),
    .awid_o(fp_awid), .awaddr_o(fp_awaddr), .awlen_o(fp_awlen), .awsize_o(fp_awsize),
    .awburst_o(fp_awburst), .awlock_o(fp_awlock), .awcache_o(fp_awcache), .awprot_o(fp_awprot),
    .awvalid_o(fp_awvalid), .awready_i(1'b0),
    .wid_o(fp_wid), .wdata_o(fp_wdata), .wstrb_o(fp_wstrb), .wlast_o(fp_wlast),
    .wvalid_o(fp_wvalid), .wready_i(1'b0),
    .bid_i(4'd0), .bresp_i(2'b00), .bvalid_i(1'b0), .bready_o(fp_bready)
  );

  // ---------------- AXI slave model ----------------
  logic r_pend, aw_got, w_got, b_pend;
  int   r_cnt, b_cnt;
  logic awg, wg;

  assign arready_i = arready_k;
  assign awready_i = awready_k;
  assign wready_i  = wready_k;
  assign rvalid_i  = r_pend && (r_cnt == 0);
  assign bvalid_i  = b_pend && (b_cnt == 0);
  assign rdata_i   = rvalid_i ? rdata_k : 32'h0;
  assign awg = aw_got || (awvalid && awready_i);
  assign wg  = w_got || (wvalid && wready_i);

  always @(posedge clk) begin
    if (rst) begin
      r_pend <= 1'b0; r_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; b_cnt <= 0;
    end else begin
      if (r_pend && r_cnt != 0) r_cnt <= r_cnt - 1;
      if (rvalid_i && rready) r_pend <= 1'b0;
      if (arvalid && arready_i) begin r_pend <= 1'b1; r_cnt <= r_delay; end
      if (b_pend && b_cnt != 0) b_cnt <= b_cnt - 1;
      if (bvalid_i && bready) b_pend <= 1'b0;
      if (awg && wg) begin
        b_pend <= 1'b1; b_cnt <= b_delay; aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        aw_got <= awg; w_got <= wg;
      end
    end
  end

  // ---------------- monitor ----------------
  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_aok [NCH], aok_cyc [NCH], n_dok [NCH], dok_cyc [NCH], fp_n_aok [NCH];
  int ar_cyc = -1, aw_cyc = -1, w_cyc = -1, b_cyc = -1;
  logic [3:0]  mon_arid, mon_awid, mon_wid, mon_wstrb;
  logic [2:0]  mon_arsize, mon_awsize;
  logic [31:0] mon_araddr, mon_awaddr, mon_wdata, mon_rdata;
  int gnt_log [$];

  initial for (int i = 0; i < NCH; i++) begin
    n_aok[i] = 0; aok_cyc[i] = -1; n_dok[i] = 0; dok_cyc[i] = -1; fp_n_aok[i] = 0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (addr_ok[i]) begin n_aok[i]++; aok_cyc[i] = cyc; gnt_log.push_back(i); end
      if (data_ok[i]) begin n_dok[i]++; dok_cyc[i] = cyc; end
      if (fp_addr_ok[i]) fp_n_aok[i]++;
    end
    if (arvalid && arready_i) begin
      ar_cyc = cyc; mon_arid = arid; mon_araddr = araddr; mon_arsize = arsize;
    end
    if (awvalid && awready_i) begin
      aw_cyc = cyc; mon_awid = awid; mon_awaddr = awaddr; mon_awsize = awsize;
    end
    if (wvalid && wready_i) begin
      w_cyc = cyc; mon_wid = wid; mon_wdata = wdata_ax; mon_wstrb = wstrb;
    end
    if (bvalid_i && bready) b_cyc = cyc;
    if (rvalid_i && rready) mon_rdata = rdata;
  end

  int checks = 0, failures = 0;

  // ---------------- helpers (stimulus and bounded waits only) ----------------
  task automatic issue(input int ch, input bit w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d, output bit to);
    @(negedge clk);
    req[ch] = 1'b1; wr[ch] = w; size[ch*2 +: 2] = sz;
    addr[ch*32 +: 32] = a; wdata[ch*32 +: 32] = d;
    to = 1'b1;
    for (int k = 0; k < 80; k++) begin
      #1;
      if (addr_ok[ch]) begin to = 1'b0; break; end
      @(negedge clk);
    end
    @(posedge clk); #1;
    req[ch] = 1'b0;
  endtask

  task automatic wait_dok(input int ch, input int target, output bit to);
    to = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (n_dok[ch] >= target) begin to = 1'b0; break; end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [15:0] got;
    @(negedge clk); @(negedge clk);
    got = {arvalid, rready, awvalid, wvalid, bready, addr_ok, data_ok, 3'b000};
    checks++;
    if (got !== 16'h0) begin failures++; $display("FAIL reset_ctrl got=%h want=0000", got); end
    checks++;
    if ({arid, awid, araddr, awaddr, wdata_ax, wstrb} !== '0) begin
      failures++; $display("FAIL reset_fields araddr=%h awaddr=%h wdata=%h wstrb=%b want 0",
                           araddr, awaddr, wdata_ax, wstrb);
    end
    checks++;
    if ({arlen, arburst, wlast} !== {8'd0, 2'b01, 1'b1}) begin
      failures++; $display("FAIL const_fields arlen=%0d arburst=%b wlast=%b want 0/01/1",
                           arlen, arburst, wlast);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    bit to; int base;
    r_delay = 3; rdata_k = 32'hDEADBEEF; base = n_dok[1];
    issue(1, 1'b0, 2'd2, 32'h1000_0004, 32'h0, to);
    wait_dok(1, base + 1, to);
    checks++;
    if (to) begin failures++; $display("FAIL single_read_timeout data_ok[1] never seen"); end
    checks++;
    if (mon_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL single_read_rdata got=%h want=deadbeef", mon_rdata); end
    checks++;
    if ({mon_arid, mon_arsize, mon_araddr} !== {4'd1, 3'd2, 32'h1000_0004}) begin
      failures++; $display("FAIL single_read_ar arid=%0d arsize=%0d araddr=%h want 1/2/10000004",
                           mon_arid, mon_arsize, mon_araddr);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (n_dok[1] !== base + 1) begin failures++; $display("FAIL single_read_once got=%0d want=%0d", n_dok[1], base + 1); end
  endtask

  task automatic test_read_latency();
    bit to; int base;
    r_delay = 0; rdata_k = 32'h1234_0001; base = n_dok[0];
    issue(0, 1'b0, 2'd2, 32'h0000_0040, 32'h0, to);
    wait_dok(0, base + 1, to);
    checks++;
    if (to || ar_cyc !== aok_cyc[0] + 1 || dok_cyc[0] !== aok_cyc[0] + 2) begin
      failures++; $display("FAIL read_latency aok=%0d ar=%0d dok=%0d want ar=aok+1 dok=aok+2",
                           aok_cyc[0], ar_cyc, dok_cyc[0]);
    end
  endtask

  task automatic test_write_strb();
    logic [1:0]  sz_t   [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
    logic [31:0] a_t    [5] = '{32'h103, 32'h101, 32'h102, 32'h100, 32'h108};
    logic [31:0] d_t    [5] = '{32'hAA000000, 32'h0000BB00, 32'hCCDD0000, 32'h0000EEFF, 32'h12345678};
    logic [3:0]  strb_t [5] = '{4'b1000, 4'b0010, 4'b1100, 4'b0011, 4'b1111};
    bit to; int base;
    for (int v = 0; v < 5; v++) begin
      b_delay = (v == 0) ? 4 : 0; base = n_dok[2];
      issue(2, 1'b1, sz_t[v], a_t[v], d_t[v], to);
      wait_dok(2, base + 1, to);
      checks++;
      if (to || mon_wstrb !== strb_t[v] || mon_wdata !== d_t[v] || mon_awsize !== {1'b0, sz_t[v]}
          || mon_awaddr !== a_t[v] || mon_awid !== 4'd2 || mon_wid !== 4'd2) begin
        failures++; $display("FAIL write_vec%0d wstrb=%b wdata=%h awsize=%0d awaddr=%h awid=%0d wid=%0d want %b/%h/%0d/%h/2/2",
                             v, mon_wstrb, mon_wdata, mon_awsize, mon_awaddr, mon_awid, mon_wid,
                             strb_t[v], d_t[v], sz_t[v], a_t[v]);
      end
      if (v == 0) begin
        checks++;
        if (dok_cyc[2] !== b_cyc || b_cyc < w_cyc + 4) begin
          failures++; $display("FAIL write_resp_wait dok=%0d b=%0d w=%0d want dok=b and b>=w+4",
                               dok_cyc[2], b_cyc, w_cyc);
        end
      end
    end
  endtask

  task automatic test_w_before_aw();
    bit to; int base;
    awready_k = 1'b0; b_delay = 0; base = n_dok[1];
    issue(1, 1'b1, 2'd2, 32'h0000_0500, 32'h5555_AAAA, to);
    repeat (3) @(negedge clk);
    checks++;
    if ({awvalid, wvalid} !== 2'b10) begin failures++; $display("FAIL w_first_hold aw/w valid=%b want 10", {awvalid, wvalid}); end
    awready_k = 1'b1;
    wait_dok(1, base + 1, to);
    checks++;
    if (to || !(w_cyc < aw_cyc) || mon_wdata !== 32'h5555_AAAA) begin
      failures++; $display("FAIL w_first_order w=%0d aw=%0d wdata=%h want w<aw wdata=5555aaaa", w_cyc, aw_cyc, mon_wdata);
    end
  endtask

  task automatic test_rr_arb();
    bit to;
    pulse_reset();
    r_delay = 0; arready_k = 1'b1;
    @(negedge clk);
    gnt_log.delete();
    wr = '0; size = {2'd2, 2'd2, 2'd2};
    addr = {32'h0000_0208, 32'h0000_0204, 32'h0000_0200};
    req = 3'b111;
    to = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (gnt_log.size() >= 4) begin to = 1'b0; break; end
    end
    @(posedge clk); #1; req = '0;
    checks++;
    if (to) begin failures++; $display("FAIL rr_timeout grants=%0d want 4", gnt_log.size()); end
    else begin
      checks++;
      if (gnt_log[0] != 0 || gnt_log[1] != 1 || gnt_log[2] != 2 || gnt_log[3] != 0) begin
        failures++; $display("FAIL rr_order got=%0d,%0d,%0d,%0d want 0,1,2,0",
                             gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_fixed_prio();
    int s0, s1, s2;
    s0 = fp_n_aok[0]; s1 = fp_n_aok[1]; s2 = fp_n_aok[2];
    repeat (12) @(negedge clk);
    checks++;
    if (fp_n_aok[0] - s0 < 3 || fp_n_aok[1] != s1 || fp_n_aok[2] != s2) begin
      failures++; $display("FAIL fixed_prio grants ch0=%0d ch1=%0d ch2=%0d want ch0>=3 others 0",
                           fp_n_aok[0] - s0, fp_n_aok[1] - s1, fp_n_aok[2] - s2);
    end
  endtask

  task automatic test_concurrent();
    bit to0, to2; int b0, b2;
    r_delay = 1; b_delay = 0; rdata_k = 32'h0C0C_0C0C; b0 = n_dok[0]; b2 = n_dok[2];
    fork
      issue(2, 1'b1, 2'd2, 32'h0000_0100, 32'hCAFE_0100, to2);
      issue(0, 1'b0, 2'd2, 32'h0000_0200, 32'h0, to0);
    join
    checks++;
    if (to0 || to2 || aok_cyc[0] !== aok_cyc[2]) begin
      failures++; $display("FAIL concurrent_addr_ok ch0=%0d ch2=%0d want same cycle", aok_cyc[0], aok_cyc[2]);
    end
    wait_dok(0, b0 + 1, to0);
    wait_dok(2, b2 + 1, to2);
    checks++;
    if (to0 || to2 || ar_cyc !== aw_cyc || mon_rdata !== 32'h0C0C_0C0C) begin
      failures++; $display("FAIL concurrent_done ar=%0d aw=%0d rdata=%h want ar=aw rdata=0c0c0c0c",
                           ar_cyc, aw_cyc, mon_rdata);
    end
  endtask

  task automatic test_hazard();
    bit to; int base;
    b_delay = 10; r_delay = 0; rdata_k = 32'h0000_0102; base = n_dok[0];
    issue(2, 1'b1, 2'd2, 32'h0000_0100, 32'h1111_2222, to);
    issue(0, 1'b0, 2'd1, 32'h0000_0102, 32'h0, to);
    wait_dok(0, base + 1, to);
    checks++;
    if (to || aok_cyc[0] !== b_cyc + 1 || ar_cyc !== b_cyc + 2) begin
      failures++; $display("FAIL hazard_block b=%0d aok=%0d ar=%0d want aok=b+1 ar=b+2", b_cyc, aok_cyc[0], ar_cyc);
    end
    b_delay = 0;
  endtask

  task automatic test_mid_reset();
    bit to; int base;
    r_delay = 20; awready_k = 1'b0; wready_k = 1'b0;
    issue(1, 1'b0, 2'd2, 32'h0000_0600, 32'h0, to);
    issue(2, 1'b1, 2'd2, 32'h0000_0700, 32'h7777_7777, to);
    @(negedge clk);
    checks++;
    if ({rready, awvalid, wvalid} !== 3'b111) begin
      failures++; $display("FAIL pre_reset_state rready/awvalid/wvalid=%b want 111", {rready, awvalid, wvalid});
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({arvalid, rready, awvalid, wvalid, bready, addr_ok, data_ok, araddr, awaddr, wstrb, wdata_ax} !== '0) begin
      failures++; $display("FAIL mid_reset ar=%b r=%b aw=%b w=%b b=%b aok=%b dok=%b araddr=%h awaddr=%h want all 0",
                           arvalid, rready, awvalid, wvalid, bready, addr_ok, data_ok, araddr, awaddr);
    end
    rst = 1'b0; awready_k = 1'b1; wready_k = 1'b1; r_delay = 0; rdata_k = 32'h0BAD_F00D;
    base = n_dok[1];
    issue(1, 1'b0, 2'd2, 32'h0000_0040, 32'h0, to);
    wait_dok(1, base + 1, to);
    checks++;
    if (to || mon_rdata !== 32'h0BAD_F00D || mon_araddr !== 32'h0000_0040) begin
      failures++; $display("FAIL post_reset_read rdata=%h araddr=%h want 0badf00d/00000040", mon_rdata, mon_araddr);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_read_latency();
    test_write_strb();
    test_w_before_aw();
    test_rr_arb();
    test_fixed_prio();
    test_concurrent();
    test_hazard();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
